// File: rtl/game_match_ctrl_if.sv
// Signal bundle between the match controller, the host/test side and the counter.
// The slave modport is the controller's view; master is the environment's view.
interface game_match_ctrl_if #(
    parameter int IVW = 4,
    parameter int SW  = 2
);
    logic           cfg_we;
    logic [IVW-1:0] cfg_init_value;
    logic [7:0]     cfg_mode_seq;
    logic [7:0]     cfg_hold;
    logic           start;
    logic           abort;

    logic           ctr_clear;
    logic           ctr_init;
    logic [1:0]     ctr_control;
    logic [IVW-1:0] ctr_initial_value;
    logic [1:0]     ctr_who;
    logic           ctr_gameover;

    logic           busy;
    logic           round_done;
    logic [SW-1:0]  score_win;
    logic [SW-1:0]  score_lose;
    logic           match_done;
    logic [1:0]     match_winner;

    modport master (
        output cfg_we, cfg_init_value, cfg_mode_seq, cfg_hold, start, abort,
        output ctr_who, ctr_gameover,
        input  ctr_clear, ctr_init, ctr_control, ctr_initial_value,
        input  busy, round_done, score_win, score_lose, match_done, match_winner
    );

    modport slave (
        input  cfg_we, cfg_init_value, cfg_mode_seq, cfg_hold, start, abort,
        input  ctr_who, ctr_gameover,
        output ctr_clear, ctr_init, ctr_control, ctr_initial_value,
        output busy, round_done, score_win, score_lose, match_done, match_winner
    );
endinterface

// File: rtl/game_match_ctrl.sv
// Best-of-N match sequencer for the multi-mode game counter: clears/loads the
// counter each round, steps its mode through a 4-entry schedule, tallies winners.
module game_match_ctrl #(
    parameter  int COUNT_MAX_VALUE = 15,
    parameter  int ROUNDS_TO_WIN   = 3,
    localparam int IVW             = $clog2(COUNT_MAX_VALUE),
    localparam int SW              = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    game_match_ctrl_if.slave   bus
);

    localparam logic [SW-1:0] RTW = SW'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_ROUND_END,
        ST_DONE
    } state_t;

    state_t         state_q,      state_d;
    logic [IVW-1:0] initValue_q,  initValue_d;
    logic [7:0]     modeSeq_q,    modeSeq_d;
    logic [7:0]     hold_q,       hold_d;
    logic [1:0]     step_q,       step_d;
    logic [7:0]     holdCnt_q,    holdCnt_d;
    logic [SW-1:0]  scoreWin_q,   scoreWin_d;
    logic [SW-1:0]  scoreLose_q,  scoreLose_d;
    logic [1:0]     winner_q,     winner_d;
    logic           abortClr_q,   abortClr_d;
    logic [7:0]     holdLast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            initValue_q <= '0;
            modeSeq_q   <= 8'h00;
            hold_q      <= 8'd1;
            step_q      <= 2'd0;
            holdCnt_q   <= 8'd0;
            scoreWin_q  <= '0;
            scoreLose_q <= '0;
            winner_q    <= 2'b00;
            abortClr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            initValue_q <= initValue_d;
            modeSeq_q   <= modeSeq_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            holdCnt_q   <= holdCnt_d;
            scoreWin_q  <= scoreWin_d;
            scoreLose_q <= scoreLose_d;
            winner_q    <= winner_d;
            abortClr_q  <= abortClr_d;
        end
    end

    // A programmed hold of 0 behaves like 1, so the step advances every cycle.
    assign holdLast = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;

    always_comb begin
        state_d     = state_q;
        initValue_d = initValue_q;
        modeSeq_d   = modeSeq_q;
        hold_d      = hold_q;
        step_d      = step_q;
        holdCnt_d   = holdCnt_q;
        scoreWin_d  = scoreWin_q;
        scoreLose_d = scoreLose_q;
        winner_d    = winner_q;
        abortClr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we) begin
                    initValue_d = bus.cfg_init_value;
                    modeSeq_d   = bus.cfg_mode_seq;
                    hold_d      = bus.cfg_hold;
                end
                if (bus.start) begin
                    state_d     = ST_CLEAR;
                    scoreWin_d  = '0;
                    scoreLose_d = '0;
                    winner_d    = 2'b00;
                end
            end
            ST_CLEAR: state_d = ST_LOAD;
            ST_LOAD: begin
                step_d    = 2'd0;
                holdCnt_d = 8'd0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                // Step is frozen on gameover so ROUND_END still shows the last mode.
                if (bus.ctr_gameover) begin
                    state_d = ST_ROUND_END;
                    if (bus.ctr_who == 2'b01 && scoreWin_q != RTW) begin
                        scoreWin_d = scoreWin_q + 1'b1;
                    end else if (bus.ctr_who == 2'b10 && scoreLose_q != RTW) begin
                        scoreLose_d = scoreLose_q + 1'b1;
                    end
                end else if (holdCnt_q >= holdLast) begin
                    holdCnt_d = 8'd0;
                    step_d    = step_q + 2'd1;
                end else begin
                    holdCnt_d = holdCnt_q + 8'd1;
                end
            end
            ST_ROUND_END: begin
                if (scoreWin_q == RTW) begin
                    winner_d = 2'b01;
                    state_d  = ST_DONE;
                end else if (scoreLose_q == RTW) begin
                    winner_d = 2'b10;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks a same-cycle gameover, so any tally from RUN is discarded.
        if (bus.abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            scoreWin_d  = scoreWin_q;
            scoreLose_d = scoreLose_q;
            winner_d    = 2'b00;
            abortClr_d  = 1'b1;
        end
    end

    assign bus.busy              = (state_q != ST_IDLE);
    assign bus.ctr_clear         = (state_q == ST_CLEAR) || abortClr_q;
    assign bus.ctr_init          = (state_q == ST_LOAD);
    assign bus.ctr_control       = (state_q == ST_RUN || state_q == ST_ROUND_END)
                                   ? modeSeq_q[{step_q, 1'b0} +: 2] : 2'b00;
    assign bus.ctr_initial_value = initValue_q;
    assign bus.round_done        = (state_q == ST_ROUND_END);
    assign bus.match_done        = (state_q == ST_DONE);
    assign bus.score_win         = scoreWin_q;
    assign bus.score_lose        = scoreLose_q;
    assign bus.match_winner      = winner_q;

endmodule

// File: doc/game_match_ctrl.md
Name: game_match_ctrl

Overview:
- Match controller that sequences the multi-mode game counter through a best-of-N match.
- Each round it clears the counter, loads the initial value, then steps the counter's control mode through a programmed 4-entry schedule.
- It watches GAMEOVER/WHO, tallies round results, and declares the match winner.
- Sits between the test/host side and the counter's design modport; it drives clear, INIT, control and initial_value.

Parameters:
- COUNT_MAX_VALUE, 15, counter maximum; IVW = $clog2(COUNT_MAX_VALUE) (4 at default).
- ROUNDS_TO_WIN, 3, rounds one side must win to end the match (legal range 1..15).
- SW, $clog2(ROUNDS_TO_WIN+1), score width (2 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_init_value  in  IVW  per-round counter initial value.
- cfg_mode_seq  in  8  four 2-bit control modes; step k = bits [2k+1:2k].
- cfg_hold  in  8  cycles spent per mode step; 0 is treated as 1.
- start  in  1  begin match; honoured only in IDLE.
- abort  in  1  terminate match from any non-IDLE state.
- ctr_clear  out  1  counter clear.
- ctr_init  out  1  counter load strobe.
- ctr_control  out  2  counter mode.
- ctr_initial_value  out  IVW  counter load value.
- ctr_who  in  2  counter WHO: 2'b01 = winner side, 2'b10 = loser side; 00/11 ignored.
- ctr_gameover  in  1  counter GAMEOVER.
- busy  out  1  high in any state except IDLE.
- round_done  out  1  one-cycle pulse per tallied round.
- score_win  out  SW  rounds won by WHO=01.
- score_lose  out  SW  rounds won by WHO=10.
- match_done  out  1  one-cycle pulse at match end.
- match_winner  out  2  01 or 10 at match end; 00 otherwise.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - config registers: init_value=0, mode_seq=8'h00, hold=1.
  - step=0, hold_cnt=0.
- All outputs are decoded from registered state/config only; there are no combinational input-to-output paths.
- IDLE:
  - ctr_control=00; ctr_initial_value=cfg reg.
  - cfg_we latches all three config fields.
  - start -> CLEAR; clears both scores and match_winner.
  - start and cfg_we in the same cycle: config is latched first, match uses the new config.
- CLEAR (1 cycle): ctr_clear=1 -> LOAD.
- LOAD (1 cycle): ctr_init=1, ctr_initial_value=init_value; step=0, hold_cnt=0 -> RUN.
- RUN:
  - ctr_control = mode_seq[step].
  - hold_cnt increments each cycle; at hold_cnt == max(hold,1)-1, hold_cnt=0 and step=(step+1) mod 4 (wraps 3->0).
  - ctr_gameover=1 -> ROUND_END.
    - WHO=01: score_win+1; WHO=10: score_lose+1; 00/11: no change, round replays.
  - Scores saturate at ROUNDS_TO_WIN.
- ROUND_END (1 cycle):
  - round_done=1; ctr_control holds last value.
  - If score_win==ROUNDS_TO_WIN, match_winner=01 -> DONE.
  - Else if score_lose==ROUNDS_TO_WIN, match_winner=10 -> DONE.
  - Else -> CLEAR.
- DONE (1 cycle): match_done=1 -> IDLE. Scores and match_winner hold until the next start.
- ctr_gameover outside RUN is ignored, including a stale GAMEOVER during CLEAR/LOAD.
- abort:
  - Any non-IDLE state -> IDLE next cycle; ctr_clear=1 for that one transition cycle.
  - Scores retained, match_winner=00, no round_done or match_done.
  - abort has priority over gameover in the same cycle.
  - abort in IDLE has no effect.
- start or cfg_we while busy: ignored.
- Round latency: start to first RUN cycle = 2 cycles (CLEAR, LOAD). Gameover to next round's RUN = 3 cycles.

Test Plan:
- Reset mid-RUN (step=2, score_win=1), assert rst -> same cycle: busy=0, all ctr_* = 0, scores 0, mode_seq=00.
- Config init=5, seq=8'b11_10_01_00, hold=3; start -> ctr_clear cycle 1, ctr_init with value 5 cycle 2; control 00,00,00,01,01,01,10,10,10,11,11,11, then 00 again (wrap).
- hold=0 -> control changes every cycle: 00,01,10,11,00.
- ROUNDS_TO_WIN=3; rounds end WHO=01,10,01,01 -> round_done x4; final scores win=3, lose=1; match_winner=01; match_done exactly one cycle after the 4th round_done; busy=0 next cycle.
- Gameover with WHO=11 -> round_done pulses, scores unchanged, new CLEAR/LOAD follows. Gameover held high through CLEAR/LOAD -> no extra tally.
- abort together with gameover in RUN, score_lose=2 -> next cycle IDLE with ctr_clear=1; score_lose stays 2, match_winner=00, no round_done. start during RUN is ignored.
